// File: rtl/audio_bitstream_shifter.sv
// -----------------------------------------------------------------------------
// audio_bitstream_shifter
//
// Bit-level bitstream server for the MP2 audio path. Takes bytes from the audio
// input FIFO into a left-aligned bit buffer and presents the oldest 16 bits as a
// peek window to the decoder. The decoder consumes 1/2/4/8/16 bits per cycle
// through a one-hot shift request.
//
// Parameters:
//   BUF_W         internal bit-buffer width (multiple of 8, >= 32)
//   REFILL_LEVEL  a byte is requested while valid-bit count <= this value
//                 (must be <= BUF_W-8 so a load can never overflow the buffer)
//
// Ports:
//   audio_decoder_clock      clock, rising edge
//   resetn                   asynchronous active-low reset
//   Byte_Data_I[7:0]         next stream byte, MSB first
//   Byte_Valid_I             Byte_Data_I holds a valid byte
//   Byte_Ready_O             byte is taken this cycle when Byte_Valid_I is high
//   Shift_En_I[4:0]          one-hot shift: [0]=1,[1]=8,[2]=16,[3]=4,[4]=2 bits
//   Bitstream_Data_O[15:0]   oldest 16 buffered bits, first-in bit at [15]
//   Bitstream_Byte_Allign_O  window starts on a byte boundary
//   Shift_Busy_O             fewer than 16 valid bits; shifts are ignored
//   Shift_Error_O            sticky, set by any multi-hot Shift_En_I
//   Bits_Consumed_O[31:0]    running count of consumed bits (wraps)
//
// Optional feature (macro SHIFTER_SYNC_SEARCH_EN):
//   Search_I                 pulse starts a sync-word search
//   Search_Done_O            one-cycle pulse when a byte-aligned 16'hFFFD is
//                            at the head of the window
// -----------------------------------------------------------------------------
module audio_bitstream_shifter #(
    parameter int BUF_W        = 32,
    parameter int REFILL_LEVEL = 24
) (
    input  logic        audio_decoder_clock,
    input  logic        resetn,
    input  logic [7:0]  Byte_Data_I,
    input  logic        Byte_Valid_I,
    output logic        Byte_Ready_O,
    input  logic [4:0]  Shift_En_I,
`ifdef SHIFTER_SYNC_SEARCH_EN
    input  logic        Search_I,
    output logic        Search_Done_O,
`endif
    output logic [15:0] Bitstream_Data_O,
    output logic        Bitstream_Byte_Allign_O,
    output logic        Shift_Busy_O,
    output logic        Shift_Error_O,
    output logic [31:0] Bits_Consumed_O
);

    localparam int CNT_W = $clog2(BUF_W + 1);
    localparam logic [CNT_W-1:0] REFILL_C = CNT_W'(REFILL_LEVEL);
    localparam logic [CNT_W-1:0] WIN_C    = CNT_W'(16);

    // Bits below the valid region are always zero; shifting in zeros and
    // OR-ing new bytes into the free region keeps that invariant.
    logic [BUF_W-1:0] buf_r;
    logic [CNT_W-1:0] count_r;
    logic [31:0]      consumed_r;
    logic             error_r;
    logic             busy_r;
    logic             ready_r;
    logic             allign_r;

    logic [CNT_W-1:0] req_amt_s;
    logic             multi_hot_s;
    logic [CNT_W-1:0] acc_amt_s;
    logic             err_set_s;
    logic             load_s;
    logic [CNT_W-1:0] remain_s;
    logic [BUF_W-1:0] shifted_s;
    logic [BUF_W-1:0] byte_pos_s;
    logic [BUF_W-1:0] buf_next_s;
    logic [CNT_W-1:0] count_next_s;

    // Decode the one-hot shift request into a bit amount and flag multi-hot.
    always_comb begin
        req_amt_s   = '0;
        multi_hot_s = ((Shift_En_I & (Shift_En_I - 5'd1)) != 5'd0);
        case (Shift_En_I)
            5'b00001: req_amt_s = CNT_W'(1);
            5'b00010: req_amt_s = CNT_W'(8);
            5'b00100: req_amt_s = CNT_W'(16);
            5'b01000: req_amt_s = CNT_W'(4);
            5'b10000: req_amt_s = CNT_W'(2);
            default:  req_amt_s = '0;
        endcase
    end

`ifdef SHIFTER_SYNC_SEARCH_EN
    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_SEARCH = 1'b1
    } search_state_t;

    search_state_t    state_r;
    search_state_t    state_next_s;
    logic             done_r;
    logic             done_next_s;
    logic [CNT_W-1:0] search_amt_s;

    // Search FSM: hunt byte-by-byte when aligned, bit-by-bit otherwise.
    always_comb begin
        state_next_s = state_r;
        done_next_s  = 1'b0;
        search_amt_s = '0;
        case (state_r)
            ST_IDLE: begin
                if (Search_I) begin
                    state_next_s = ST_SEARCH;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_SEARCH: begin
                if (busy_r) begin
                    search_amt_s = '0;
                end else if (allign_r && (buf_r[BUF_W-1 -: 16] == 16'hFFFD)) begin
                    done_next_s  = 1'b1;
                    state_next_s = ST_IDLE;
                end else if (allign_r) begin
                    search_amt_s = CNT_W'(8);
                end else begin
                    search_amt_s = CNT_W'(1);
                end
            end
            default: state_next_s = ST_IDLE;
        endcase
    end

    // Shift source: the search engine owns the shifter while searching.
    always_comb begin
        acc_amt_s = '0;
        err_set_s = 1'b0;
        if (state_r == ST_SEARCH) begin
            acc_amt_s = search_amt_s;
        end else begin
            acc_amt_s = busy_r ? '0 : req_amt_s;
            err_set_s = multi_hot_s;
        end
    end

    // Search state and done pulse registers.
    always_ff @(posedge audio_decoder_clock or negedge resetn) begin
        if (!resetn) begin
            state_r <= ST_IDLE;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_next_s;
            done_r  <= done_next_s;
        end
    end

    assign Search_Done_O = done_r;
`else
    // Shift source: decoder requests only, accepted when the window is valid.
    always_comb begin
        acc_amt_s = '0;
        err_set_s = multi_hot_s;
        if (busy_r) begin
            acc_amt_s = '0;
        end else begin
            acc_amt_s = req_amt_s;
        end
    end
`endif

    // Next buffer: shift out consumed bits, append the new byte right after
    // whatever valid bits remain.
    always_comb begin
        load_s       = ready_r & Byte_Valid_I;
        remain_s     = count_r - acc_amt_s;
        shifted_s    = buf_r << acc_amt_s;
        byte_pos_s   = {Byte_Data_I, {(BUF_W-8){1'b0}}} >> remain_s;
        buf_next_s   = shifted_s;
        count_next_s = remain_s;
        if (load_s) begin
            buf_next_s   = shifted_s | byte_pos_s;
            count_next_s = remain_s + CNT_W'(8);
        end else begin
            buf_next_s   = shifted_s;
            count_next_s = remain_s;
        end
    end

    // Buffer, counters and status flags; flags follow the new count directly.
    always_ff @(posedge audio_decoder_clock or negedge resetn) begin
        if (!resetn) begin
            buf_r      <= '0;
            count_r    <= '0;
            consumed_r <= 32'd0;
            error_r    <= 1'b0;
            busy_r     <= 1'b1;
            ready_r    <= 1'b0;
            allign_r   <= 1'b1;
        end else begin
            buf_r      <= buf_next_s;
            count_r    <= count_next_s;
            consumed_r <= consumed_r + 32'(acc_amt_s);
            error_r    <= error_r | err_set_s;
            busy_r     <= (count_next_s < WIN_C);
            ready_r    <= (count_next_s <= REFILL_C);
            allign_r   <= (count_next_s[2:0] == 3'd0);
        end
    end

    assign Bitstream_Data_O        = buf_r[BUF_W-1 -: 16];
    assign Bitstream_Byte_Allign_O = allign_r;
    assign Shift_Busy_O            = busy_r;
    assign Shift_Error_O           = error_r;
    assign Byte_Ready_O            = ready_r;
    assign Bits_Consumed_O         = consumed_r;

endmodule

// File: tb/tb_audio_bitstream_shifter.sv
// Directed bench for audio_bitstream_shifter (default build, no search).
module tb_audio_bitstream_shifter;

    logic        audio_decoder_clock;
    logic        resetn;
    logic [7:0]  Byte_Data_I;
    logic        Byte_Valid_I;
    logic        Byte_Ready_O;
    logic [4:0]  Shift_En_I;
    logic [15:0] Bitstream_Data_O;
    logic        Bitstream_Byte_Allign_O;
    logic        Shift_Busy_O;
    logic        Shift_Error_O;
    logic [31:0] Bits_Consumed_O;

    int checks = 0;
    int passes = 0;
    int fails  = 0;

    audio_bitstream_shifter dut (
        .audio_decoder_clock     (audio_decoder_clock),
        .resetn                  (resetn),
        .Byte_Data_I             (Byte_Data_I),
        .Byte_Valid_I            (Byte_Valid_I),
        .Byte_Ready_O            (Byte_Ready_O),
        .Shift_En_I              (Shift_En_I),
        .Bitstream_Data_O        (Bitstream_Data_O),
        .Bitstream_Byte_Allign_O (Bitstream_Byte_Allign_O),
        .Shift_Busy_O            (Shift_Busy_O),
        .Shift_Error_O           (Shift_Error_O),
        .Bits_Consumed_O         (Bits_Consumed_O)
    );

    initial audio_decoder_clock = 1'b0;
    always #5 audio_decoder_clock = ~audio_decoder_clock;

    task automatic tick();
        @(posedge audio_decoder_clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) begin
            passes++;
        end else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        resetn       = 1'b0;
        Byte_Data_I  = 8'h00;
        Byte_Valid_I = 1'b0;
        Shift_En_I   = 5'b00000;
        #12;
        check("rst_data",     32'(Bitstream_Data_O), 32'h0000);
        check("rst_allign",   32'(Bitstream_Byte_Allign_O), 32'd1);
        check("rst_busy",     32'(Shift_Busy_O), 32'd1);
        check("rst_ready",    32'(Byte_Ready_O), 32'd0);
        check("rst_error",    32'(Shift_Error_O), 32'd0);
        check("rst_consumed", Bits_Consumed_O, 32'd0);
        resetn = 1'b1;

        tick();
        check("ready_up", 32'(Byte_Ready_O), 32'd1);

        // Stream FF FD 12 34 with valid held high.
        Byte_Valid_I = 1'b1;
        Byte_Data_I  = 8'hFF;
        tick();
        check("busy_1byte", 32'(Shift_Busy_O), 32'd1);
        check("win_1byte",  32'(Bitstream_Data_O), 32'hFF00);
        Byte_Data_I = 8'hFD;
        tick();
        check("busy_2byte",   32'(Shift_Busy_O), 32'd0);
        check("win_fffd",     32'(Bitstream_Data_O), 32'hFFFD);
        check("allign_fffd",  32'(Bitstream_Byte_Allign_O), 32'd1);
        Byte_Data_I = 8'h12;
        tick();
        check("ready_at_24", 32'(Byte_Ready_O), 32'd1);
        Byte_Data_I = 8'h34;
        tick();
        check("ready_at_32", 32'(Byte_Ready_O), 32'd0);
        check("win_full",    32'(Bitstream_Data_O), 32'hFFFD);
        Byte_Data_I = 8'h56;
        tick();
        check("held_off_win", 32'(Bitstream_Data_O), 32'hFFFD);
        Byte_Valid_I = 1'b0;

        // 1-bit then 4-bit shift on buffer FFFD1234.
        Shift_En_I = 5'b00001;
        tick();
        check("sh1_win",      32'(Bitstream_Data_O), 32'hFFFA);
        check("sh1_allign",   32'(Bitstream_Byte_Allign_O), 32'd0);
        check("sh1_consumed", Bits_Consumed_O, 32'd1);
        Shift_En_I = 5'b01000;
        tick();
        check("sh4_win",      32'(Bitstream_Data_O), 32'hFFA2);
        check("sh4_allign",   32'(Bitstream_Byte_Allign_O), 32'd0);
        check("sh4_consumed", Bits_Consumed_O, 32'd5);

        // Multi-hot request: ignored, sticky error.
        Shift_En_I = 5'b00011;
        tick();
        check("mh_error",    32'(Shift_Error_O), 32'd1);
        check("mh_win",      32'(Bitstream_Data_O), 32'hFFA2);
        check("mh_consumed", Bits_Consumed_O, 32'd5);
        Shift_En_I = 5'b00000;
        tick();
        check("err_sticky", 32'(Shift_Error_O), 32'd1);
        check("zero_noop",  Bits_Consumed_O, 32'd5);

        // 16-bit shift drains below the window; next one must be ignored.
        Shift_En_I = 5'b00100;
        tick();
        check("sh16_win",      32'(Bitstream_Data_O), 32'h4680);
        check("sh16_busy",     32'(Shift_Busy_O), 32'd1);
        check("sh16_consumed", Bits_Consumed_O, 32'd21);
        tick();
        check("busy_ign_win",      32'(Bitstream_Data_O), 32'h4680);
        check("busy_ign_consumed", Bits_Consumed_O, 32'd21);
        Shift_En_I   = 5'b00000;
        Byte_Valid_I = 1'b1;
        Byte_Data_I  = 8'hAB;
        tick();
        check("refill_win",    32'(Bitstream_Data_O), 32'h4695);
        check("refill_busy",   32'(Shift_Busy_O), 32'd0);
        check("refill_allign", 32'(Bitstream_Byte_Allign_O), 32'd0);
        Byte_Valid_I = 1'b0;

        // Mid-stream reset drops everything, clears the error.
        resetn = 1'b0;
        #2;
        check("mrst_data",     32'(Bitstream_Data_O), 32'h0000);
        check("mrst_busy",     32'(Shift_Busy_O), 32'd1);
        check("mrst_error",    32'(Shift_Error_O), 32'd0);
        check("mrst_consumed", Bits_Consumed_O, 32'd0);
        check("mrst_allign",   32'(Bitstream_Byte_Allign_O), 32'd1);
        resetn = 1'b1;
        tick();

        // Fill to 24 bits: 11 22 33.
        Byte_Valid_I = 1'b1;
        Byte_Data_I  = 8'h11;
        tick();
        Byte_Data_I = 8'h22;
        tick();
        Byte_Data_I = 8'h33;
        tick();
        check("fill24_win",   32'(Bitstream_Data_O), 32'h1122);
        check("fill24_ready", 32'(Byte_Ready_O), 32'd1);

        // Simultaneous 8-bit shift and load at count 24: 11223300 -> 22334400.
        Byte_Data_I = 8'h44;
        Shift_En_I  = 5'b00010;
        tick();
        check("simul1_win",      32'(Bitstream_Data_O), 32'h2233);
        check("simul1_consumed", Bits_Consumed_O, 32'd8);
        check("simul1_ready",    32'(Byte_Ready_O), 32'd1);
        Byte_Data_I = 8'h55;
        tick();
        check("simul2_win",      32'(Bitstream_Data_O), 32'h3344);
        check("simul2_consumed", Bits_Consumed_O, 32'd16);

        // Drain 16: only byte 55 remains.
        Byte_Valid_I = 1'b0;
        Shift_En_I   = 5'b00100;
        tick();
        check("drain_win",      32'(Bitstream_Data_O), 32'h5500);
        check("drain_busy",     32'(Shift_Busy_O), 32'd1);
        check("drain_allign",   32'(Bitstream_Byte_Allign_O), 32'd1);
        check("drain_consumed", Bits_Consumed_O, 32'd32);
        Shift_En_I = 5'b00000;
        tick();

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
